// File: rtl/spi_dac_pkg.sv
// Shared constants and types for the SPI DAC link receiver.
package spi_dac_pkg;

   localparam int DATA_W_DEF      = 12;
   localparam int LEAD_BITS_DEF   = 1;
   localparam int SYNC_STAGES_DEF = 2;

   // Receiver frame-tracking states.
   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      LEAD = 2'd2,
      DATA = 2'd3
   } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line plus single-cycle
// rise/fall strobes derived from the synchronized value.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Shift the pin through the synchronizer chain; the extra flop holds the
   // previous synced value for edge detection. Reset loads the line's idle level
   // so no spurious edge appears on release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync <= {SYNC_STAGES{IDLE_VAL}};
         r_prev <= IDLE_VAL;
      end else begin
         r_sync[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign sync_out = r_sync[SYNC_STAGES-1];
   assign rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign fall     = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI receiver for the 12-bit DAC link. Oversamples CS/SCLK/MOSI on clk,
// rebuilds LSB-first words and hands them out on a valid/ready port, flagging
// malformed frames and dropped words.
module spi_dac_rx
   import spi_dac_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int LEAD_BITS   = LEAD_BITS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SCLK,
   input  logic              CS,
   input  logic              MOSI,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int BIT_CNT_W  = $clog2(DATA_W + 2);
   localparam int LEAD_CNT_W = ($clog2(LEAD_BITS + 1) < 1) ? 1 : $clog2(LEAD_BITS + 1);
   localparam int ARM_CNT_W  = ($clog2(SYNC_STAGES + 1) < 1) ? 1 : $clog2(SYNC_STAGES + 1);

   localparam logic [BIT_CNT_W-1:0]  BIT_FULL = BIT_CNT_W'(DATA_W);
   localparam logic [BIT_CNT_W-1:0]  BIT_SAT  = BIT_CNT_W'(DATA_W + 1);
   localparam logic [LEAD_CNT_W-1:0] LEAD_TOP = LEAD_CNT_W'(LEAD_BITS);
   localparam logic [ARM_CNT_W-1:0]  ARM_DONE = ARM_CNT_W'(SYNC_STAGES);

   // Synchronized inputs and edge strobes
   logic w_sclk_s, w_sclk_rise, w_sclk_fall;
   logic w_cs_s, w_cs_rise, w_cs_fall;
   logic w_mosi_s;
   logic w_unused_sclk;

   logic [SYNC_STAGES-1:0] r_mosi_sync;

   // Frame tracking
   rx_state_t              r_state;
   logic [ARM_CNT_W-1:0]   r_arm_cnt;
   logic [LEAD_CNT_W-1:0]  r_lead_cnt;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_err;
   logic [DATA_W-1:0]      r_sr;

   // Output holding register
   logic [DATA_W-1:0]      r_dout;
   logic                   r_dout_valid;
   logic                   r_frame_err;
   logic                   r_overrun;

   logic [LEAD_CNT_W-1:0]  w_lead_inc;
   logic                   w_in_frame;
   logic                   w_good;
   logic                   w_bad;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (SCLK),
      .sync_out (w_sclk_s),
      .rise     (w_sclk_rise),
      .fall     (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (CS),
      .sync_out (w_cs_s),
      .rise     (w_cs_rise),
      .fall     (w_cs_fall)
   );

   // Only SCLK falling edges carry data; level and rising edge are not needed.
   assign w_unused_sclk = w_sclk_s ^ w_sclk_rise;

   // MOSI needs the same latency as SCLK so the bit is aligned with its strobe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mosi_sync <= '0;
      end else begin
         r_mosi_sync[0] <= MOSI;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_mosi_sync[i] <= r_mosi_sync[i-1];
         end
      end
   end

   assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
   assign w_lead_inc = r_lead_cnt + 1'b1;
   assign w_in_frame = (r_state == LEAD) || (r_state == DATA);

   // A frame closes on cs_rise; cs_rise wins over a coincident SCLK fall, so
   // the count checked is the one held before that edge.
   assign w_good = (r_state == DATA) && w_cs_rise && (r_bit_cnt == BIT_FULL) && !r_err;
   assign w_bad  = w_in_frame && w_cs_rise && !w_good;

   // Frame state machine. ARM first lets the synchronizers flush the reset
   // idle values, then waits for a genuine CS-high so a frame already running
   // at reset release is ignored rather than half-captured.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ARM;
         r_arm_cnt  <= '0;
         r_lead_cnt <= '0;
         r_bit_cnt  <= '0;
         r_err      <= 1'b0;
         r_sr       <= '0;
      end else begin
         case (r_state)
            ARM: begin
               if (r_arm_cnt != ARM_DONE) begin
                  r_arm_cnt <= r_arm_cnt + 1'b1;
               end else if (w_cs_s) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               if (w_cs_fall) begin
                  r_lead_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_err      <= 1'b0;
                  r_state    <= (LEAD_BITS == 0) ? DATA : LEAD;
               end
            end
            LEAD: begin
               if (w_cs_rise) begin
                  r_state <= IDLE;
               end else if (w_sclk_fall) begin
                  r_lead_cnt <= w_lead_inc;
                  if (w_lead_inc == LEAD_TOP) begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_cs_rise) begin
                  r_state <= IDLE;
               end else if (w_sclk_fall) begin
                  if (r_bit_cnt != BIT_SAT) begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
                  // Extra bits mark the frame bad but never disturb the word.
                  if (r_bit_cnt >= BIT_FULL) begin
                     r_err <= 1'b1;
                  end else begin
                     r_sr <= {w_mosi_s, r_sr[DATA_W-1:1]};
                  end
               end
            end
            default: r_state <= ARM;
         endcase
      end
   end

   // Holding register and status pulses. A new word replaces the old one only
   // if the old one is gone or being taken this cycle; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err <= w_bad;
         r_overrun   <= w_good && r_dout_valid && !dout_ready;
         if (w_good && (!r_dout_valid || dout_ready)) begin
            r_dout       <= r_sr;
            r_dout_valid <= 1'b1;
         end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;
   assign busy       = w_in_frame;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Self-checking bench for spi_dac_rx: a behavioural SPI transmitter drives
// frames, expected words go into a scoreboard queue and are popped on each
// dout handshake.
module tb_spi_dac_rx;
   import spi_dac_pkg::*;

   localparam int HALF = 6;   // SCLK half-period in clk cycles

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        SCLK = 1'b0;
   logic        CS = 1'b1;
   logic        MOSI = 1'b0;
   logic [11:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic        frame_err;
   logic        overrun;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_hs     = 0;
   int n_ferr   = 0;
   int n_ovr    = 0;

   logic [11:0] sb_q[$];

   typedef struct {
      logic [15:0] data;
      int          nbits;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   spi_dac_rx dut (
      .clk        (clk),
      .reset      (reset),
      .SCLK       (SCLK),
      .CS         (CS),
      .MOSI       (MOSI),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: handshakes pop the scoreboard; status pulses are counted.
   always @(negedge clk) begin
      if (reset) begin
         if (dout_valid && dout_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
               check("unexpected_word", int'(dout), -1);
            end else begin
               logic [11:0] exp_w;
               exp_w = sb_q.pop_front();
               check("dout_word", int'(dout), int'(exp_w));
               $display("handshake: dout=0x%03h expected=0x%03h", dout, exp_w);
            end
         end
         if (frame_err) n_ferr++;
         if (overrun)   n_ovr++;
         if (frame_err && overrun) check("err_ovr_exclusive", 1, 0);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sclk_pulse(input logic b);
      MOSI = b;
      SCLK = 1'b1;
      wait_cyc(HALF);
      SCLK = 1'b0;
      wait_cyc(HALF);
   endtask

   task automatic spi_frame(input logic [15:0] data, input int nbits);
      CS = 1'b0;
      wait_cyc(HALF);
      sclk_pulse(1'b0);                 // lead bit, no data
      for (int i = 0; i < nbits; i++) begin
         sclk_pulse(data[i]);
      end
      CS = 1'b1;
      wait_cyc(HALF);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, f0, o0;

      vecs[0] = '{16'h0A5C, 12, 1'b0};
      vecs[1] = '{16'h0001, 12, 1'b0};
      vecs[2] = '{16'h0800, 12, 1'b0};
      vecs[3] = '{16'h00AB,  8, 1'b1};
      vecs[4] = '{16'h03C3, 12, 1'b0};
      vecs[5] = '{16'h35A5, 14, 1'b1};

      // Reset state
      wait_cyc(4);
      check("rst_dout", int'(dout), 0);
      check("rst_valid", int'(dout_valid), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_ovr", int'(overrun), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b1;
      wait_cyc(8);

      // Table-driven frames with the consumer always ready
      for (int v = 0; v < 6; v++) begin
         h0 = n_hs; f0 = n_ferr; o0 = n_ovr;
         if (!vecs[v].exp_err) sb_q.push_back(vecs[v].data[11:0]);
         spi_frame(vecs[v].data, vecs[v].nbits);
         wait_cyc(10);
         $display("frame %0d: data=0x%03h bits=%0d hs=%0d ferr=%0d ovr=%0d",
                  v, vecs[v].data[11:0], vecs[v].nbits, n_hs - h0, n_ferr - f0, n_ovr - o0);
         check("vec_handshakes", n_hs - h0, vecs[v].exp_err ? 0 : 1);
         check("vec_frame_err", n_ferr - f0, int'(vecs[v].exp_err));
         check("vec_overrun", n_ovr - o0, 0);
         check("vec_busy_idle", int'(busy), 0);
      end

      // Overrun: second word dropped while the first is held
      dout_ready = 1'b0;
      h0 = n_hs; f0 = n_ferr; o0 = n_ovr;
      sb_q.push_back(12'h123);
      spi_frame(16'h0123, 12);
      wait_cyc(10);
      check("ovr_first_valid", int'(dout_valid), 1);
      check("ovr_first_dout", int'(dout), 'h123);
      spi_frame(16'h0456, 12);
      wait_cyc(10);
      $display("overrun seq: dout=0x%03h valid=%0d ovr=%0d", dout, dout_valid, n_ovr - o0);
      check("ovr_pulse", n_ovr - o0, 1);
      check("ovr_hold_dout", int'(dout), 'h123);
      check("ovr_hold_valid", int'(dout_valid), 1);
      check("ovr_no_ferr", n_ferr - f0, 0);
      check("ovr_no_hs", n_hs - h0, 0);
      @(posedge clk); #1;
      dout_ready = 1'b1;
      wait_cyc(5);
      check("ovr_drain_hs", n_hs - h0, 1);
      check("ovr_drain_valid", int'(dout_valid), 0);

      // Reset in the middle of a frame; the remainder must be ignored
      h0 = n_hs; f0 = n_ferr;
      CS = 1'b0;
      wait_cyc(HALF);
      sclk_pulse(1'b0);
      for (int i = 0; i < 5; i++) sclk_pulse(1'b1);
      check("mid_busy", int'(busy), 1);
      reset = 1'b0;
      wait_cyc(3);
      check("mid_rst_dout", int'(dout), 0);
      check("mid_rst_valid", int'(dout_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      reset = 1'b1;
      for (int i = 0; i < 7; i++) sclk_pulse(1'b1);
      CS = 1'b1;
      wait_cyc(HALF + 10);
      $display("mid-frame reset: hs=%0d ferr=%0d", n_hs - h0, n_ferr - f0);
      check("mid_no_hs", n_hs - h0, 0);
      check("mid_no_ferr", n_ferr - f0, 0);
      sb_q.push_back(12'hFFF);
      spi_frame(16'h0FFF, 12);
      wait_cyc(10);
      check("post_rst_hs", n_hs - h0, 1);
      check("post_rst_ferr", n_ferr - f0, 0);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
